// File: rtl/uart_pkg.sv
// Shared definitions for the serial subsystem autobaud path: FSM states,
// divider width and the sync-character framing constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_WAIT_FALL,
    ST_MEASURE,
    ST_DIVIDE
  } state_t;

  // Width of the divider numerator (CLKFREQ*8 plus rounding term).
  localparam int NUM_W = 40;

  // 'U' on an 8N1 line gives 0101010101: five falling edges over 8 bit times.
  localparam logic [7:0] SYNC_CHAR  = 8'h55;
  localparam int         EDGE_COUNT = 5;

endpackage

// File: rtl/seq_divider.sv
// Generic iterative restoring divider: one quotient bit per clock, NUM_W
// clocks per division. start loads a new operand pair while idle, flush
// cancels a division in flight, done pulses once with quo valid.
module seq_divider #(
  parameter int NUM_W = 40,
  parameter int DEN_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quo
);

  localparam int CW = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] quo_q, quo_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   diff;

  // Shift the next numerator bit into the partial remainder; a clear top
  // bit of the difference means the divisor fits.
  assign trial = {rem_q, quo_q[NUM_W-1]};
  assign diff  = trial - {1'b0, den_q};

  // Load, iterate and finish: the numerator register doubles as the quotient.
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (flush) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      if (!diff[DEN_W]) begin
        rem_d = diff[DEN_W-1:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DEN_W-1:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      quo_d  = num;
      rem_d  = '0;
      den_d  = den;
      cnt_d  = CW'(NUM_W);
      busy_d = 1'b1;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quo  = quo_q;

endmodule

// File: rtl/uart_autobaud.sv
// Autobaud detector: times the five falling edges of a 'U' sync character
// and divides to get baud = CLKFREQ*8/span, plus rounded clocks per bit.
// Optional macro UART_AUTOBAUD_CHECK_EN adds an interval-consistency check
// that rejects characters other than 'U' and noisy lines.
module uart_autobaud #(
  parameter int CLKFREQ  = 1000000,
  parameter int CNT_W    = 24,
  parameter int IDLE_CYC = 16
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             rx,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      baud,
  output logic [CNT_W-1:0] bit_cycles
);

  import uart_pkg::*;

  localparam int               IDLE_W   = $clog2(IDLE_CYC + 1);
  localparam logic [NUM_W-1:0] BASE_NUM = NUM_W'(64'(CLKFREQ) * 64'd8);
  localparam logic [CNT_W-1:0] SPAN_MAX = '1;
  localparam logic [CNT_W-1:0] SPAN_MIN = CNT_W'(16);

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_sync_q, rx_sync_d;
  logic             rx_prev_q, rx_prev_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] span_q, span_d;
  logic [CNT_W-1:0] int_q, int_d;
  logic [CNT_W-1:0] span_cap_q, span_cap_d;
  logic [2:0]       edge_idx_q, edge_idx_d;
  logic [31:0]      baud_q, baud_d;
  logic [CNT_W-1:0] bitc_q, bitc_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             fall;
  logic [CNT_W-1:0] span_inc;
  logic [CNT_W-1:0] int_inc;
  logic             span_ovf;
  logic             last_edge;
  logic             too_fast;
  logic             interval_bad;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [NUM_W-1:0] div_num;
  logic [NUM_W-1:0] div_quo;
  logic             quo_ovf;

  assign fall      = rx_prev_q & ~rx_sync_q;
  assign span_inc  = span_q + 1'b1;
  assign int_inc   = int_q + 1'b1;
  assign span_ovf  = (state_q == ST_MEASURE) && (span_inc == SPAN_MAX);
  assign last_edge = (edge_idx_q == 3'(EDGE_COUNT - 1));
  assign too_fast  = (span_inc < SPAN_MIN);
  assign div_num   = BASE_NUM + NUM_W'(span_inc >> 1);
  assign quo_ovf   = |div_quo[NUM_W-1:32];

`ifdef UART_AUTOBAUD_CHECK_EN
  logic [CNT_W-1:0] i0_q, i0_d;
  logic [CNT_W-1:0] int_diff;

  // Each interval after the first must stay within a quarter of the first.
  assign int_diff     = (int_inc >= i0_q) ? (int_inc - i0_q) : (i0_q - int_inc);
  assign interval_bad = fall && (state_q == ST_MEASURE) && (edge_idx_q >= 3'd2) &&
                        (int_diff > (i0_q >> 2));

  // Reference interval register, captured at the second falling edge.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) i0_q <= '0;
    else         i0_q <= i0_d;
  end
`else
  assign interval_bad = 1'b0;
`endif

  seq_divider #(
    .NUM_W(NUM_W),
    .DEN_W(CNT_W)
  ) u_div (
    .clk  (clk),
    .rst_n(resetq),
    .start(div_start),
    .flush(abort),
    .num  (div_num),
    .den  (span_inc),
    .busy (div_busy),
    .done (div_done),
    .quo  (div_quo)
  );

  // Two-flop synchronizer followed by the edge-detect register.
  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; abort from any active state overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start && !abort) state_d = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (rx_sync_q && (idle_cnt_q == IDLE_W'(IDLE_CYC - 1))) state_d = ST_WAIT_FALL;
      ST_WAIT_FALL: if (fall) state_d = ST_MEASURE;
      ST_MEASURE: begin
        if (span_ovf || interval_bad) state_d = ST_IDLE;
        else if (fall && last_edge)   state_d = too_fast ? ST_IDLE : ST_DIVIDE;
      end
      ST_DIVIDE:    if (div_done || !div_busy) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // Counters, capture, divider launch and result/pulse generation per state.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    span_d     = span_q;
    int_d      = int_q;
    edge_idx_d = edge_idx_q;
    span_cap_d = span_cap_q;
    baud_d     = baud_q;
    bitc_d     = bitc_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    div_start  = 1'b0;
`ifdef UART_AUTOBAUD_CHECK_EN
    i0_d       = i0_q;
`endif
    unique case (state_q)
      ST_IDLE:      idle_cnt_d = '0;
      ST_WAIT_IDLE: idle_cnt_d = rx_sync_q ? (idle_cnt_q + 1'b1) : '0;
      ST_WAIT_FALL: begin
        if (fall) begin
          span_d     = '0;
          int_d      = '0;
          edge_idx_d = 3'd1;
        end
      end
      ST_MEASURE: begin
        span_d = span_inc;
        int_d  = int_inc;
        if (span_ovf) begin
          err_d = 1'b1;
        end else if (fall) begin
          int_d      = '0;
          edge_idx_d = edge_idx_q + 3'd1;
`ifdef UART_AUTOBAUD_CHECK_EN
          if (edge_idx_q == 3'd1) i0_d = int_inc;
`endif
          if (interval_bad) begin
            err_d = 1'b1;
          end else if (last_edge) begin
            span_cap_d = span_inc;
            if (too_fast) err_d = 1'b1;
            else          div_start = 1'b1;
          end
        end
      end
      ST_DIVIDE: begin
        if (div_done) begin
          if (quo_ovf) begin
            err_d = 1'b1;
          end else begin
            done_d = 1'b1;
            baud_d = div_quo[31:0];
            bitc_d = CNT_W'(({1'b0, span_cap_q} + (CNT_W + 1)'(4)) >> 3);
          end
        end else if (!div_busy) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      done_d    = 1'b0;
      err_d     = 1'b0;
      div_start = 1'b0;
      baud_d    = baud_q;
      bitc_d    = bitc_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_meta_q  <= 1'b0;
      rx_sync_q  <= 1'b0;
      rx_prev_q  <= 1'b0;
      idle_cnt_q <= '0;
      span_q     <= '0;
      int_q      <= '0;
      span_cap_q <= '0;
      edge_idx_q <= '0;
      baud_q     <= '0;
      bitc_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      idle_cnt_q <= idle_cnt_d;
      span_q     <= span_d;
      int_q      <= int_d;
      span_cap_q <= span_cap_d;
      edge_idx_q <= edge_idx_d;
      baud_q     <= baud_d;
      bitc_q     <= bitc_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign baud       = baud_q;
  assign bit_cycles = bitc_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Testbench for uart_autobaud at CLKFREQ=12 MHz. A second instance with a
// 12-bit counter covers the span-overflow path. Results are checked through
// a scoreboard of expected done/err events.
module tb_uart_autobaud;

  localparam int CLKF = 12000000;

  typedef struct {
    int          clk_per_bit;
    logic        is_err;
    logic [31:0] baud;
    logic [23:0] bitc;
  } vec_t;

  typedef struct {
    logic        is_err;
    logic [31:0] baud;
    logic [23:0] bitc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        rx = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;

  logic        busy, done, err;
  logic [31:0] baud;
  logic [23:0] bit_cycles;
  logic        busy2, done2, err2;
  logic [31:0] baud2;
  logic [11:0] bit_cycles2;

  exp_t sb[$];
  vec_t vecs[6];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   fall5_cyc = 0;

  uart_autobaud #(.CLKFREQ(CLKF), .CNT_W(24), .IDLE_CYC(16)) dut (
    .clk(clk), .resetq(resetq), .rx(rx), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err), .baud(baud), .bit_cycles(bit_cycles)
  );

  uart_autobaud #(.CLKFREQ(CLKF), .CNT_W(12), .IDLE_CYC(16)) dut2 (
    .clk(clk), .resetq(resetq), .rx(rx), .start(start), .abort(abort),
    .busy(busy2), .done(done2), .err(err2), .baud(baud2), .bit_cycles(bit_cycles2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic armAndIdle();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (24) @(negedge clk);
  endtask

  task automatic sendEdges(input int iv[4], input int low_len, input bit mid_start);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < low_len; j++) begin
        @(negedge clk);
        rx = 1'b0;
        start = (mid_start && k == 2 && j == 0);
        if (k == 4 && j == 0) fall5_cyc = cyc;
      end
      if (k < 4) begin
        for (int j = 0; j < iv[k] - low_len; j++) begin
          @(negedge clk);
          rx = 1'b1;
          start = 1'b0;
        end
      end
    end
    @(negedge clk);
    rx = 1'b1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   iv[4];
    e.is_err = v.is_err;
    e.baud   = v.baud;
    e.bitc   = v.bitc;
    sb.push_back(e);
    for (int i = 0; i < 4; i++) iv[i] = 2 * v.clk_per_bit;
    armAndIdle();
    sendEdges(iv, v.clk_per_bit, 1'b0);
    waitDrain(200);
  endtask

  // Scoreboard monitor for the main instance.
  initial begin
    exp_t e;
    bit   chk_busy_next = 1'b0;
    forever begin
      @(negedge clk);
      if (resetq) begin
        if (chk_busy_next) checkOutput("busy_after_pulse", busy, 0);
        chk_busy_next = done || err;
        if (done || err) begin
          checkOutput("done_err_exclusive", done & err, 0);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_pulse: got done=%0b err=%0b expected no pulse", done, err);
          end else begin
            e = sb.pop_front();
            checkOutput("pulse_is_err", err, e.is_err);
            if (done && !e.is_err) begin
              checkOutput("baud", baud, e.baud);
              checkOutput("bit_cycles", bit_cycles, e.bitc);
              checkOutput("done_latency", cyc - fall5_cyc, 44);
            end
          end
        end
      end else begin
        chk_busy_next = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int iv[4];
    int f, n;

    vecs[0] = '{1250, 1'b0, 32'd9600,    24'd1250};
    vecs[1] = '{500,  1'b0, 32'd24000,   24'd500};
    vecs[2] = '{104,  1'b0, 32'd115385,  24'd104};
    vecs[3] = '{2,    1'b0, 32'd6000000, 24'd2};
    vecs[4] = '{1,    1'b1, 32'd0,       24'd0};
    vecs[5] = '{200,  1'b0, 32'd60000,   24'd200};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_baud", baud, 0);
    checkOutput("rst_bitc", bit_cycles, 0);
    checkOutput("rst_busy2", busy2, 0);
    checkOutput("rst_baud2", baud2, 0);
    @(negedge clk); resetq = 1'b1;
    repeat (4) @(negedge clk);

    // Table-driven measurements
    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d: %0d clk/bit", i, vecs[i].clk_per_bit);
      applyStimulus(vecs[i]);
    end

    // Span overflow on the 12-bit instance: line held low after the start edge
    $display("[TB] span overflow");
    checkOutput("ovf_pre_busy2", busy2, 0);
    armAndIdle();
    @(negedge clk); rx = 1'b0; f = cyc;
    n = 0;
    while (!err2 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ovf_err2", err2, 1);
    checkOutput("ovf_done2", done2, 0);
    checkOutput("ovf_cycle_window", ((cyc - f) >= 4096) && ((cyc - f) <= 4100), 1);
    @(negedge clk);
    checkOutput("ovf_busy2_after", busy2, 0);
    checkOutput("ovf_baud2_kept", baud2, 60000);
    checkOutput("ovf_bitc2_kept", bit_cycles2, 200);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0; rx = 1'b1;
    checkOutput("ovf_abort_busy", busy, 0);
    repeat (4) @(negedge clk);

    // Irregular intervals 208,208,300,208
    $display("[TB] irregular intervals");
    begin
      exp_t e;
`ifdef UART_AUTOBAUD_CHECK_EN
      e = '{1'b1, 32'd0, 24'd0};
`else
      e = '{1'b0, 32'd103896, 24'd116};
`endif
      sb.push_back(e);
    end
    iv = '{208, 208, 300, 208};
    armAndIdle();
    sendEdges(iv, 104, 1'b0);
    waitDrain(200);

    // start pulsed again mid-measurement must be ignored
    $display("[TB] start during measure");
    begin
      exp_t e;
      e = '{1'b0, 32'd115385, 24'd104};
      sb.push_back(e);
    end
    iv = '{208, 208, 208, 208};
    armAndIdle();
    sendEdges(iv, 104, 1'b1);
    waitDrain(200);

    // Reset asserted mid-divide clears everything at once
    $display("[TB] reset during divide");
    armAndIdle();
    sendEdges(iv, 10, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("div_busy_before_rst", busy, 1);
    #1 resetq = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_err", err, 0);
    checkOutput("midrst_baud", baud, 0);
    checkOutput("midrst_bitc", bit_cycles, 0);
    @(negedge clk); resetq = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(vecs[1]);

    // abort during WAIT_FALL keeps the previous result
    $display("[TB] abort in wait-fall");
    armAndIdle();
    checkOutput("wf_busy_before_abort", busy, 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checkOutput("wf_busy_after_abort", busy, 0);
    iv = '{208, 208, 208, 208};
    sendEdges(iv, 104, 1'b0);
    repeat (60) @(negedge clk);
    checkOutput("wf_baud_kept", baud, 24000);
    checkOutput("wf_bitc_kept", bit_cycles, 500);

    // start and abort together while idle: stays idle
    $display("[TB] start+abort in idle");
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checkOutput("sa_busy", busy, 0);
    repeat (5) @(negedge clk);
    checkOutput("sa_busy_later", busy, 0);

    checkOutput("sb_empty_end", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
